// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Ops are accepted only while idle; long ops hold busy for a fixed count.
// Optional feature macro: MDU_MADD_EN enables madd/maddu (ops 7/8).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] MDU_in1,
  input  logic [31:0] MDU_in2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mdu_req_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  mdu_req_t         req_q;

  // Decode of the incoming op: which ops occupy the unit, and for how long
  logic in_mul, in_div;
  always_comb begin
    in_mul = (MDUop == OP_MULT) || (MDUop == OP_MULTU) ||
             (MADD_EN && ((MDUop == OP_MADD) || (MDUop == OP_MADDU)));
    in_div = (MDUop == OP_DIV) || (MDUop == OP_DIVU);
  end

  // Datapath on the latched request; HI/LO cannot change during RUN, so the
  // accumulate for madd sees the values present at acceptance
  logic [63:0] a_ext, b_ext, prod, acc;
  logic        sgn_mul, sgn_div, a_neg, b_neg;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  always_comb begin
    sgn_mul = (req_q.op == OP_MULT) || (req_q.op == OP_MADD);
    a_ext   = sgn_mul ? {{32{req_q.a[31]}}, req_q.a} : {32'b0, req_q.a};
    b_ext   = sgn_mul ? {{32{req_q.b[31]}}, req_q.b} : {32'b0, req_q.b};
    prod    = a_ext * b_ext;
    acc     = {HI, LO} + prod;

    // Signed divide through magnitudes: avoids the 0x80000000 / -1 overflow
    sgn_div = (req_q.op == OP_DIV);
    a_neg   = sgn_div & req_q.a[31];
    b_neg   = sgn_div & req_q.b[31];
    ua      = a_neg ? (~req_q.a + 32'd1) : req_q.a;
    ub      = b_neg ? (~req_q.b + 32'd1) : req_q.b;
    uq      = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur      = (ub == 32'd0) ? 32'd0 : ua % ub;
    q       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    r       = a_neg ? (~ur + 32'd1) : ur;

    res_hi = HI;
    res_lo = LO;
    res_wr = 1'b0;
    case (req_q.op)
      OP_MULT, OP_MULTU: begin
        {res_hi, res_lo} = prod;
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = r;
        res_lo = q;
        res_wr = (req_q.b != 32'd0);
      end
      OP_MADD, OP_MADDU: begin
        {res_hi, res_lo} = acc;
        res_wr = MADD_EN;
      end
      default: ;
    endcase
  end

  // Control FSM: accept in IDLE, count down in RUN, write HI/LO on the last edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      req_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (in_mul || in_div) begin
              req_q <= '{op: MDUop, a: MDU_in1, b: MDU_in2};
              cnt   <= in_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= RUN;
            end else if (MDUop == OP_MTHI) begin
              HI <= MDU_in1;
            end else if (MDUop == OP_MTLO) begin
              LO <= MDU_in1;
            end
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (res_wr) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized checks of mult_div_unit against
// an arithmetic reference model of HI/LO. Honours MDU_MADD_EN like the DUT.
module tb_mult_div_unit;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDUop = 4'd0;
  logic [31:0] MDU_in1 = '0, MDU_in2 = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
    .MDU_in1(MDU_in1), .MDU_in2(MDU_in2), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference semantics: what HI/LO become after op, and how long busy holds
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int cyc);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0] hl;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = a; ub = b;
    nh = m_hi; nl = m_lo; cyc = 0;
    case (op)
      4'd1: begin sp = sa * sb; {nh, nl} = sp; cyc = MULT_CYCLES; end
      4'd2: begin up = ua * ub; {nh, nl} = up; cyc = MULT_CYCLES; end
      4'd3: begin
        cyc = DIV_CYCLES;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
      end
      4'd4: begin
        cyc = DIV_CYCLES;
        if (b != 0) begin up = ua / ub; nl = up[31:0]; up = ua % ub; nh = up[31:0]; end
      end
      4'd5: nh = a;
      4'd6: nl = a;
      4'd7: if (MADD_EN) begin
        sp = sa * sb; hl = {m_hi, m_lo} + 64'(sp); {nh, nl} = hl; cyc = MULT_CYCLES;
      end
      4'd8: if (MADD_EN) begin
        up = ua * ub; hl = {m_hi, m_lo} + up; {nh, nl} = hl; cyc = MULT_CYCLES;
      end
      default: ;
    endcase
  endtask

  // Issue one op from idle; optionally hammer start with junk while busy
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    logic [31:0] nh, nl;
    int cyc;
    model(op, a, b, nh, nl, cyc);
    @(negedge clk);
    start = 1'b1; MDUop = op; MDU_in1 = a; MDU_in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk($sformatf("busy op%0d c%0d", op, i), 64'(busy), 64'd1);
      chk($sformatf("hold op%0d c%0d", op, i), {HI, LO}, {m_hi, m_lo});
      if (disturb) begin
        start = 1'b1; MDUop = 4'($urandom_range(1, 8));
        MDU_in1 = $urandom; MDU_in2 = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    m_hi = nh; m_lo = nl;
    chk($sformatf("idle op%0d", op), 64'(busy), 64'd0);
    chk($sformatf("hilo op%0d", op), {HI, LO}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hilo", {HI, LO}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("mult const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu const", {HI, LO}, 64'h00000001_FFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    chk("div const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd5, 32'h1234, 32'd0, 1'b0);
    run_op(4'd4, 32'd77, 32'd0, 1'b0);
    chk("divu0 const", {HI, LO}, 64'h00001234_FFFFFFFD);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div ovf const", {HI, LO}, 64'h00000000_80000000);

    // madd accumulate across the LO->HI carry
    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(4'd8, 32'd1, 32'd1, 1'b1);
    chk("maddu const", {HI, LO}, MADD_EN ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);

    // undefined op codes do nothing
    for (int op = 9; op < 16; op++) run_op(4'(op), $urandom, $urandom, 1'b0);

    // reset in the middle of a div
    @(negedge clk);
    start = 1'b1; MDUop = 4'd3; MDU_in1 = 32'd100; MDU_in2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(4'd6, 32'h55, 32'd0, 1'b0);
    chk("mtlo after rst", 64'(LO), 64'h55);

    // randomized ops
    for (int n = 0; n < 40; n++)
      run_op(4'($urandom_range(0, 9)), pick(), pick(), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
